// File: rtl/serial_sub_pkg.sv
// Shared state encoding and defaults for the bit-serial subtractor controller.
package serial_sub_pkg;

   localparam logic [1:0] S_IDLE = 2'b00;
   localparam logic [1:0] S_RUN  = 2'b01;
   localparam logic [1:0] S_DONE = 2'b10;

   localparam int unsigned SUB_WIDTH_DEFAULT = 8;

   typedef enum logic [1:0] {
      StIdle = S_IDLE,
      StRun  = S_RUN,
      StDone = S_DONE
   } state_e;

endpackage

// File: rtl/full_sub_cell.sv
// 1-bit full subtractor: two half subtractors with their borrows ORed.
module full_sub_cell (
   input  logic a,
   input  logic b,
   input  logic bin,
   output logic d,
   output logic bout
);

   logic d1, b1, b2;

   half_sub u_hs0 (
      .a   (a),
      .b   (b),
      .d   (d1),
      .bout(b1)
   );

   half_sub u_hs1 (
      .a   (d1),
      .b   (bin),
      .d   (d),
      .bout(b2)
   );

   assign bout = b1 | b2;

endmodule

// File: rtl/half_sub.sv
// 1-bit half subtractor: d = a - b, bout set when b exceeds a.
module half_sub (
   input  logic a,
   input  logic b,
   output logic d,
   output logic bout
);

   assign d    = a ^ b;
   assign bout = ~a & b;

endmodule

// File: rtl/serial_sub_ctrl.sv
// Bit-serial WIDTH-bit subtractor: diff = a - b, LSB first, one bit per clock,
// with a start/busy/done handshake and a result held until the next op completes.
module serial_sub_ctrl
   import serial_sub_pkg::*;
#(
   parameter int unsigned WIDTH = SUB_WIDTH_DEFAULT
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             start,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   output logic             busy,
   output logic             done,
   output logic [WIDTH-1:0] diff,
   output logic             borrow_out
);

   localparam int unsigned CntW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

   state_e           state_q, state_d;
   logic [WIDTH-1:0] a_sr_q, a_sr_d;
   logic [WIDTH-1:0] b_sr_q, b_sr_d;
   logic [WIDTH-1:0] res_sr_q, res_sr_d;
   logic [WIDTH-1:0] diff_q, diff_d;
   logic [CntW-1:0]  cnt_q, cnt_d;
   logic             brw_q, brw_d;
   logic             borrow_q, borrow_d;
   logic             done_q, done_d;
   logic             cell_d, cell_bout;

   full_sub_cell u_cell (
      .a   (a_sr_q[0]),
      .b   (b_sr_q[0]),
      .bin (brw_q),
      .d   (cell_d),
      .bout(cell_bout)
   );

   always_comb begin
      state_d  = state_q;
      a_sr_d   = a_sr_q;
      b_sr_d   = b_sr_q;
      res_sr_d = res_sr_q;
      diff_d   = diff_q;
      cnt_d    = cnt_q;
      brw_d    = brw_q;
      borrow_d = borrow_q;
      done_d   = 1'b0;
      unique case (state_q)
         StIdle: begin
            if (start) begin
               a_sr_d  = a;
               b_sr_d  = b;
               brw_d   = 1'b0;
               cnt_d   = '0;
               state_d = StRun;
            end
         end
         StRun: begin
            a_sr_d   = a_sr_q >> 1;
            b_sr_d   = b_sr_q >> 1;
            res_sr_d = {cell_d, res_sr_q[WIDTH-1:1]};
            brw_d    = cell_bout;
            cnt_d    = cnt_q + CntW'(1);
            // Last bit: publish the fully shifted result together with the final borrow.
            if (cnt_q == CntW'(WIDTH - 1)) begin
               diff_d   = {cell_d, res_sr_q[WIDTH-1:1]};
               borrow_d = cell_bout;
               done_d   = 1'b1;
               state_d  = StDone;
            end
         end
         StDone: state_d = StIdle;
         default: state_d = StIdle;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q  <= StIdle;
         a_sr_q   <= '0;
         b_sr_q   <= '0;
         res_sr_q <= '0;
         diff_q   <= '0;
         cnt_q    <= '0;
         brw_q    <= 1'b0;
         borrow_q <= 1'b0;
         done_q   <= 1'b0;
      end else begin
         state_q  <= state_d;
         a_sr_q   <= a_sr_d;
         b_sr_q   <= b_sr_d;
         res_sr_q <= res_sr_d;
         diff_q   <= diff_d;
         cnt_q    <= cnt_d;
         brw_q    <= brw_d;
         borrow_q <= borrow_d;
         done_q   <= done_d;
      end
   end

   assign busy       = (state_q != StIdle);
   assign done       = done_q;
   assign diff       = diff_q;
   assign borrow_out = borrow_q;

endmodule

// File: tb/tb_serial_sub_ctrl.sv
// Self-checking bench for serial_sub_ctrl: 8-bit and 4-bit instances against an arithmetic model.
module tb_serial_sub_ctrl;

   logic       clk = 1'b0;
   logic       rst_n;
   logic       start8, start4;
   logic [7:0] a8, b8, diff8;
   logic [3:0] a4, b4, diff4;
   logic       busy8, done8, borrow8;
   logic       busy4, done4, borrow4;
   logic       use4;

   int n_cmp  = 0;
   int n_fail = 0;

   always #5 clk = ~clk;

   serial_sub_ctrl #(.WIDTH(8)) dut8 (
      .clk       (clk),
      .rst_n     (rst_n),
      .start     (start8),
      .a         (a8),
      .b         (b8),
      .busy      (busy8),
      .done      (done8),
      .diff      (diff8),
      .borrow_out(borrow8)
   );

   serial_sub_ctrl #(.WIDTH(4)) dut4 (
      .clk       (clk),
      .rst_n     (rst_n),
      .start     (start4),
      .a         (a4),
      .b         (b4),
      .busy      (busy4),
      .done      (done4),
      .diff      (diff4),
      .borrow_out(borrow4)
   );

   logic       m_busy, m_done, m_borrow;
   logic [7:0] m_diff;
   assign m_busy   = use4 ? busy4 : busy8;
   assign m_done   = use4 ? done4 : done8;
   assign m_borrow = use4 ? borrow4 : borrow8;
   assign m_diff   = use4 ? {4'h0, diff4} : diff8;

   // Reference: plain modular subtraction and unsigned compare.
   function automatic logic [7:0] ref_diff(input int w, input logic [7:0] x, input logic [7:0] y);
      int unsigned m;
      m = (1 << w) - 1;
      return 8'(((x & m) - (y & m)) & m);
   endfunction

   function automatic logic ref_borrow(input int w, input logic [7:0] x, input logic [7:0] y);
      int unsigned m;
      m = (1 << w) - 1;
      return (x & m) < (y & m);
   endfunction

   // One accepted op; reports result, latency in edges, busy after accept, done width and stability.
   task automatic do_op(input logic sel4, input logic [7:0] av, input logic [7:0] bv,
                        output logic [7:0] dv, output logic bo, output int lat,
                        output logic busy1, output logic done_after, output logic stable);
      logic [7:0] d0;
      @(negedge clk);
      use4 = sel4;
      if (sel4) begin a4 = av[3:0]; b4 = bv[3:0]; start4 = 1'b1; end
      else begin a8 = av; b8 = bv; start8 = 1'b1; end
      #1 d0 = m_diff;
      @(negedge clk);
      start8 = 1'b0;
      start4 = 1'b0;
      a8 = 8'($urandom);
      b8 = 8'($urandom);
      a4 = 4'($urandom);
      b4 = 4'($urandom);
      busy1  = m_busy;
      lat    = -1;
      stable = 1'b1;
      for (int i = 1; i <= 40; i++) begin
         @(negedge clk);
         if (m_done) begin lat = i; break; end
         if (m_diff !== d0) stable = 1'b0;
      end
      dv = m_diff;
      bo = m_borrow;
      @(negedge clk);
      done_after = m_done;
   endtask

   task automatic test_reset();
      n_cmp++;
      if ({busy8, done8, diff8, borrow8} !== 11'h0) begin
         n_fail++;
         $display("FAIL reset8: got busy=%b done=%b diff=%h brw=%b, want all 0",
                  busy8, done8, diff8, borrow8);
      end
      n_cmp++;
      if ({busy4, done4, diff4, borrow4} !== 7'h0) begin
         n_fail++;
         $display("FAIL reset4: got busy=%b done=%b diff=%h brw=%b, want all 0",
                  busy4, done4, diff4, borrow4);
      end
   endtask

   task automatic check_op(input string nm, input logic sel4, input logic [7:0] av,
                           input logic [7:0] bv);
      logic [7:0] dv;
      logic       bo, busy1, dafter, stable;
      int         lat, w;
      w = sel4 ? 4 : 8;
      do_op(sel4, av, bv, dv, bo, lat, busy1, dafter, stable);
      n_cmp++;
      if (dv !== ref_diff(w, av, bv) || bo !== ref_borrow(w, av, bv)) begin
         n_fail++;
         $display("FAIL %s: %h-%h got diff=%h brw=%b, want diff=%h brw=%b", nm, av, bv, dv, bo,
                  ref_diff(w, av, bv), ref_borrow(w, av, bv));
      end
      n_cmp++;
      if (lat != w || busy1 !== 1'b1 || dafter !== 1'b0 || stable !== 1'b1) begin
         n_fail++;
         $display("FAIL %s_timing: lat=%0d busy=%b done_next=%b stable=%b, want %0d 1 0 1",
                  nm, lat, busy1, dafter, stable, w);
      end
   endtask

   task automatic test_directed();
      check_op("sub_5a_3c", 1'b0, 8'h5A, 8'h3C);
      check_op("sub_3c_5a", 1'b0, 8'h3C, 8'h5A);
      check_op("sub_00_01", 1'b0, 8'h00, 8'h01);
      check_op("sub_ff_ff", 1'b0, 8'hFF, 8'hFF);
      check_op("sub_00_00", 1'b0, 8'h00, 8'h00);
   endtask

   task automatic test_random();
      for (int i = 0; i < 24; i++) check_op("rand8", 1'b0, 8'($urandom), 8'($urandom));
   endtask

   task automatic test_ignore_busy();
      logic ok;
      int   lat;
      use4 = 1'b0;
      @(negedge clk);
      a8 = 8'h5A; b8 = 8'h3C; start8 = 1'b1;
      @(negedge clk);
      start8 = 1'b0;
      repeat (2) @(negedge clk);
      a8 = 8'h00; b8 = 8'hFF; start8 = 1'b1;
      @(negedge clk);
      start8 = 1'b0;
      lat = -1;
      for (int i = 4; i <= 40; i++) begin
         @(negedge clk);
         if (done8) begin lat = i; break; end
      end
      n_cmp++;
      if (lat != 8 || diff8 !== 8'h1E || borrow8 !== 1'b0) begin
         n_fail++;
         $display("FAIL ignore_busy: lat=%0d diff=%h brw=%b, want 8 1e 0", lat, diff8, borrow8);
      end
      ok = 1'b1;
      repeat (5) begin
         @(negedge clk);
         if (busy8 !== 1'b0 || done8 !== 1'b0) ok = 1'b0;
      end
      n_cmp++;
      if (ok !== 1'b1) begin
         n_fail++;
         $display("FAIL no_queue: got busy/done activity=%b, want idle", ~ok);
      end
   endtask

   task automatic test_back_to_back();
      logic [7:0] ra, rb;
      logic       bz1, bz2;
      int         gap;
      use4 = 1'b0;
      ra = 8'($urandom);
      rb = 8'($urandom);
      @(negedge clk);
      a8 = 8'h5A; b8 = 8'h3C; start8 = 1'b1;
      for (int i = 0; i < 40; i++) begin
         @(negedge clk);
         if (done8) break;
      end
      n_cmp++;
      if (done8 !== 1'b1 || diff8 !== 8'h1E) begin
         n_fail++;
         $display("FAIL b2b_first: done=%b diff=%h, want 1 1e", done8, diff8);
      end
      a8 = ra; b8 = rb;
      gap = -1; bz1 = 1'bx; bz2 = 1'bx;
      for (int c = 1; c <= 40; c++) begin
         @(negedge clk);
         if (c == 1) bz1 = busy8;
         if (c == 2) bz2 = busy8;
         if (done8) begin gap = c; break; end
      end
      start8 = 1'b0;
      n_cmp++;
      if (gap != 10 || bz1 !== 1'b0 || bz2 !== 1'b1) begin
         n_fail++;
         $display("FAIL b2b_gap: gap=%0d busy1=%b busy2=%b, want 10 0 1", gap, bz1, bz2);
      end
      n_cmp++;
      if (diff8 !== ref_diff(8, ra, rb) || borrow8 !== ref_borrow(8, ra, rb)) begin
         n_fail++;
         $display("FAIL b2b_second: diff=%h brw=%b, want %h %b", diff8, borrow8,
                  ref_diff(8, ra, rb), ref_borrow(8, ra, rb));
      end
      repeat (3) @(negedge clk);
   endtask

   task automatic test_reset_mid();
      logic ok;
      use4 = 1'b0;
      @(negedge clk);
      a8 = 8'hA0; b8 = 8'h01; start8 = 1'b1;
      @(negedge clk);
      start8 = 1'b0;
      repeat (3) @(negedge clk);
      #2 rst_n = 1'b0;
      #1;
      n_cmp++;
      if (busy8 !== 1'b0 || done8 !== 1'b0 || diff8 !== 8'h00 || borrow8 !== 1'b0) begin
         n_fail++;
         $display("FAIL reset_mid: busy=%b done=%b diff=%h brw=%b, want 0 0 00 0",
                  busy8, done8, diff8, borrow8);
      end
      @(negedge clk);
      rst_n = 1'b1;
      ok = 1'b1;
      repeat (12) begin
         @(negedge clk);
         if (done8 !== 1'b0 || busy8 !== 1'b0) ok = 1'b0;
      end
      n_cmp++;
      if (ok !== 1'b1) begin
         n_fail++;
         $display("FAIL reset_no_done: activity after abort=%b, want none", ~ok);
      end
      check_op("after_reset", 1'b0, 8'h10, 8'h01);
   endtask

   task automatic test_width4();
      check_op("w4_3_5", 1'b1, 8'h03, 8'h05);
      for (int i = 0; i < 8; i++) check_op("rand4", 1'b1, 8'($urandom), 8'($urandom));
      use4 = 1'b0;
   endtask

   initial begin
      rst_n  = 1'b0;
      start8 = 1'b0;
      start4 = 1'b0;
      a8 = '0; b8 = '0; a4 = '0; b4 = '0;
      use4 = 1'b0;
      #3;
      test_reset();
      @(negedge clk);
      @(negedge clk);
      rst_n = 1'b1;
      test_directed();
      test_random();
      test_ignore_busy();
      test_back_to_back();
      test_reset_mid();
      test_width4();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
      $finish;
   end

endmodule
